// File: rtl/nn_pkg.sv
// Shared definitions for the MLP layer sequencers: sizes, Q1.15 limits and FSM states.
package nn_pkg;

  localparam int unsigned N_IN   = 4;
  localparam int unsigned N_HID  = 8;
  localparam int unsigned FRAC   = 15;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 36;

  // Activation range after ReLU and saturation.
  localparam logic signed [DATA_W-1:0] Q15_MAX  = 16'sh7fff;
  localparam logic signed [DATA_W-1:0] RELU_MIN = 16'sh0000;

  typedef enum logic [1:0] {
    StIdle,
    StBias,
    StMac,
    StAct
  } state_e;

endpackage

// File: rtl/relu_sat.sv
// Converts a Q.30 accumulator to a Q1.15 activation: floor shift, ReLU, saturate at 32767.
module relu_sat
  import nn_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] h
);

  localparam int unsigned SW = ACC_W - FRAC;

  logic signed [SW-1:0] s;
  logic                 unused_frac;

  // Dropping the low bits of a two's-complement value is a floor division by 2^FRAC.
  assign s           = acc[ACC_W-1:FRAC];
  assign unused_frac = ^acc[FRAC-1:0];

  always_comb begin
    h = RELU_MIN;
    if (s[SW-1]) begin
      h = RELU_MIN;
    end else if (s > {{(SW-DATA_W){1'b0}}, Q15_MAX}) begin
      h = Q15_MAX;
    end else begin
      h = s[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/hidden_layer_sequencer.sv
// Input-to-hidden MLP layer: walks the external weight/bias ROMs over 8 neurons, sharing
// one 16x16 multiplier across the 4 features, and streams out ReLU-saturated activations.
module hidden_layer_sequencer
  import nn_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [15:0]  x0,
  input  logic signed [15:0]  x1,
  input  logic signed [15:0]  x2,
  input  logic signed [15:0]  x3,
  output logic        [2:0]   rom_addr,
  input  logic signed [15:0]  w1,
  input  logic signed [15:0]  w2,
  input  logic signed [15:0]  w3,
  input  logic signed [15:0]  w4,
  input  logic signed [15:0]  b1,
  output logic                busy,
  output logic                h_valid,
  output logic        [2:0]   h_idx,
  output logic signed [15:0]  h_data,
  output logic        [127:0] h_vec,
  output logic                done
);

  localparam logic [1:0] LAST_K = 2'(N_IN - 1);
  localparam logic [2:0] LAST_N = 3'(N_HID - 1);

  state_e                          state_q, state_d;
  logic        [2:0]               neuron_q, neuron_d;
  logic        [1:0]               k_q, k_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic        [N_IN-1:0][DATA_W-1:0] x_q;
  logic                            busy_q, h_valid_q, done_q;
  logic        [2:0]               h_idx_q;
  logic signed [DATA_W-1:0]        h_data_q;
  logic        [127:0]             h_vec_q;

  logic                            x_load, act_fire;
  logic signed [DATA_W-1:0]        x_sel, w_sel, h_act;
  logic signed [2*DATA_W-1:0]      prod;
  logic signed [ACC_W-1:0]         prod_ext, bias_ext;

  always_comb begin
    w_sel = w1;
    case (k_q)
      2'd0:    w_sel = w1;
      2'd1:    w_sel = w2;
      2'd2:    w_sel = w3;
      default: w_sel = w4;
    endcase
  end

  assign x_sel    = $signed(x_q[k_q]);
  assign prod     = x_sel * w_sel;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W-FRAC){b1[DATA_W-1]}}, b1, {FRAC{1'b0}}};

  relu_sat u_relu_sat (
    .acc (acc_q),
    .h   (h_act)
  );

  always_comb begin
    state_d  = state_q;
    neuron_d = neuron_q;
    k_d      = k_q;
    acc_d    = acc_q;
    x_load   = 1'b0;
    act_fire = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          x_load   = 1'b1;
          neuron_d = '0;
          state_d  = StBias;
        end
      end
      StBias: begin
        acc_d   = bias_ext;
        k_d     = '0;
        state_d = StMac;
      end
      StMac: begin
        acc_d = acc_q + prod_ext;
        k_d   = k_q + 2'd1;
        if (k_q == LAST_K) begin
          state_d = StAct;
        end
      end
      StAct: begin
        act_fire = 1'b1;
        if (neuron_q == LAST_N) begin
          state_d = StIdle;
        end else begin
          neuron_d = neuron_q + 3'd1;
          state_d  = StBias;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      neuron_q  <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      busy_q    <= 1'b0;
      h_valid_q <= 1'b0;
      done_q    <= 1'b0;
      h_idx_q   <= '0;
      h_data_q  <= '0;
      h_vec_q   <= '0;
    end else begin
      state_q   <= state_d;
      neuron_q  <= neuron_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      busy_q    <= (state_d != StIdle);
      h_valid_q <= act_fire;
      done_q    <= act_fire && (neuron_q == LAST_N);
      if (x_load) begin
        x_q <= {x3, x2, x1, x0};
      end
      // h_vec keeps stale slots from the previous run until each neuron overwrites its own.
      if (act_fire) begin
        h_data_q                             <= h_act;
        h_idx_q                              <= neuron_q;
        h_vec_q[DATA_W*neuron_q +: DATA_W]   <= h_act;
      end
    end
  end

  assign rom_addr = neuron_q;
  assign busy     = busy_q;
  assign h_valid  = h_valid_q;
  assign h_idx    = h_idx_q;
  assign h_data   = h_data_q;
  assign h_vec    = h_vec_q;
  assign done     = done_q;

endmodule

// File: tb/tb_hidden_layer_sequencer.sv
// Randomized bench for hidden_layer_sequencer with an arithmetic reference model of the layer.
module tb_hidden_layer_sequencer;

  typedef logic [3:0][15:0] xvec_t;

  logic                clk = 1'b0;
  logic                rst_n, start;
  logic signed [15:0]  x0, x1, x2, x3, w1, w2, w3, w4, b1;
  logic        [2:0]   rom_addr, h_idx;
  logic                busy, h_valid, done;
  logic signed [15:0]  h_data;
  logic        [127:0] h_vec;

  logic [15:0] wrom [8][4];
  logic [15:0] brom [8];

  int total = 0;
  int bad   = 0;

  int          edge_cnt = 0;
  logic [2:0]  s_idx   [512];
  logic [15:0] s_data  [512];
  int          s_stamp [512];
  int          d_stamp [64];
  int          n_strobe = 0;
  int          n_done   = 0;

  always #5 clk = ~clk;

  hidden_layer_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .x0       (x0),
    .x1       (x1),
    .x2       (x2),
    .x3       (x3),
    .rom_addr (rom_addr),
    .w1       (w1),
    .w2       (w2),
    .w3       (w3),
    .w4       (w4),
    .b1       (b1),
    .busy     (busy),
    .h_valid  (h_valid),
    .h_idx    (h_idx),
    .h_data   (h_data),
    .h_vec    (h_vec),
    .done     (done)
  );

  // Combinational ROMs addressed by the DUT.
  assign w1 = wrom[rom_addr][0];
  assign w2 = wrom[rom_addr][1];
  assign w3 = wrom[rom_addr][2];
  assign w4 = wrom[rom_addr][3];
  assign b1 = brom[rom_addr];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Stamp = number of rising edges so far; an event after edge Ej of a run stamps e0+j.
  always @(negedge clk) begin
    if (h_valid === 1'b1 && n_strobe < 512) begin
      s_idx[n_strobe]   = h_idx;
      s_data[n_strobe]  = h_data;
      s_stamp[n_strobe] = edge_cnt;
      n_strobe++;
    end
    if (done === 1'b1 && n_done < 64) begin
      d_stamp[n_done] = edge_cnt;
      n_done++;
    end
  end

  // Reference: h = clamp(floor((b*2^15 + sum x_i*w_i) / 2^15), 0, 32767).
  function automatic logic [15:0] model_h(input int n, input xvec_t xv);
    longint acc;
    acc = longint'($signed(brom[n])) * 64'sd32768;
    for (int i = 0; i < 4; i++) acc += longint'($signed(xv[i])) * longint'($signed(wrom[n][i]));
    acc = acc >>> 15;
    if (acc < 0) return 16'd0;
    if (acc > 32767) return 16'd32767;
    return acc[15:0];
  endfunction

  task automatic set_x(input xvec_t xv);
    x0 = xv[0];
    x1 = xv[1];
    x2 = xv[2];
    x3 = xv[3];
  endtask

  task automatic rand_roms();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) wrom[n][i] = 16'($urandom);
      brom[n] = 16'($urandom);
    end
  endtask

  // Launches one run; extra start pulses are driven so they are sampled at edges p1/p2.
  task automatic drive_run(input xvec_t xv, input int p1, input int p2, input bit hold_next,
                           input bit pre_started, output int e0, output int busy_bad);
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
      set_x(xv);
    end
    @(negedge clk);
    start = 1'b0;
    e0 = edge_cnt;
    set_x(xvec_t'({$urandom, $urandom}));
    busy_bad = 0;
    for (int j = 0; j < 48; j++) begin
      if (busy !== 1'b1) busy_bad++;
      start = (j + 1 == p1 || j + 1 == p2);
      @(negedge clk);
    end
    if (busy !== 1'b0) busy_bad++;
    start = hold_next;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    set_x('0);
    repeat (3) @(negedge clk);
    total++;
    if ({busy, h_valid, done, h_idx, h_data, rom_addr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b hv=%b done=%b idx=%0d data=%0d addr=%0d want all 0",
               busy, h_valid, done, h_idx, h_data, rom_addr);
    end
    total++;
    if (h_vec !== '0) begin
      bad++;
      $display("FAIL reset_hvec got=%h want=0", h_vec);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_patterns();
    xvec_t xv;
    int e0, bb, sb, db;
    logic [127:0] ev;
    logic [15:0] eh;
    for (int p = 0; p < 8; p++) begin
      rand_roms();
      xv = '0;
      for (int n = 0; n < 8; n++) begin
        if (p < 3) brom[n] = 16'd0;
        else if (p == 3) brom[n] = 16'd16384;
        else if (p == 4) brom[n] = 16'hffff;
      end
      if (p == 1) xv[0] = 16'h7fff;
      if (p == 2) begin
        xv[0] = 16'h7fff;
        xv[2] = 16'h7fff;
        wrom[0][0] = 16'd28000;
        wrom[0][2] = 16'd21085;
        wrom[4][0] = 16'd27866;
        wrom[4][2] = 16'h8000;
      end
      if (p >= 5) xv = xvec_t'({$urandom, $urandom});
      sb = n_strobe;
      db = n_done;
      drive_run(xv, -1, -1, 1'b0, 1'b0, e0, bb);
      repeat (3) @(negedge clk);
      total++;
      if (bb !== 0) begin
        bad++;
        $display("FAIL pat%0d_busy bad_cycles=%0d want 0", p, bb);
      end
      total++;
      if (n_strobe - sb !== 8 || n_done - db !== 1 || d_stamp[db] !== e0 + 48) begin
        bad++;
        $display("FAIL pat%0d_count strobes=%0d dones=%0d done_at=%0d want 8 1 %0d",
                 p, n_strobe - sb, n_done - db, d_stamp[db] - e0, 48);
      end
      for (int n = 0; n < 8; n++) begin
        eh = model_h(n, xv);
        ev[16*n +: 16] = eh;
        total++;
        if (s_idx[sb+n] !== 3'(n) || s_data[sb+n] !== eh || s_stamp[sb+n] !== e0 + 6*n + 6) begin
          bad++;
          $display("FAIL pat%0d_strobe%0d got idx=%0d data=%0d at=%0d want idx=%0d data=%0d at=%0d",
                   p, n, s_idx[sb+n], s_data[sb+n], s_stamp[sb+n] - e0, n, eh, 6*n + 6);
        end
      end
      total++;
      if (h_vec !== ev) begin
        bad++;
        $display("FAIL pat%0d_hvec got=%h want=%h", p, h_vec, ev);
      end
    end
  endtask

  task automatic test_ignore_start();
    xvec_t xv;
    int e0, bb, sb, db;
    logic [15:0] eh;
    rand_roms();
    xv = xvec_t'({$urandom, $urandom});
    sb = n_strobe;
    db = n_done;
    drive_run(xv, 10, 30, 1'b0, 1'b0, e0, bb);
    repeat (10) @(negedge clk);
    total++;
    if (bb !== 0 || n_strobe - sb !== 8 || n_done - db !== 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start busy_bad=%0d strobes=%0d dones=%0d busy=%b want 0 8 1 0",
               bb, n_strobe - sb, n_done - db, busy);
    end
    for (int n = 0; n < 8; n++) begin
      eh = model_h(n, xv);
      total++;
      if (s_idx[sb+n] !== 3'(n) || s_data[sb+n] !== eh || s_stamp[sb+n] !== e0 + 6*n + 6) begin
        bad++;
        $display("FAIL ignore_strobe%0d got idx=%0d data=%0d at=%0d want idx=%0d data=%0d at=%0d",
                 n, s_idx[sb+n], s_data[sb+n], s_stamp[sb+n] - e0, n, eh, 6*n + 6);
      end
    end
  endtask

  task automatic test_back_to_back();
    xvec_t xa, xb;
    int e0a, e0b, bba, bbb, sb, db;
    logic [15:0] eh;
    rand_roms();
    xa = xvec_t'({$urandom, $urandom});
    xb = xvec_t'({$urandom, $urandom});
    sb = n_strobe;
    db = n_done;
    drive_run(xa, -1, -1, 1'b1, 1'b0, e0a, bba);
    set_x(xb);
    drive_run(xb, -1, -1, 1'b0, 1'b1, e0b, bbb);
    repeat (3) @(negedge clk);
    total++;
    if (bba !== 0 || bbb !== 0 || n_strobe - sb !== 16 || n_done - db !== 2 ||
        d_stamp[db+1] !== e0a + 97) begin
      bad++;
      $display("FAIL b2b_count busy_bad=%0d/%0d strobes=%0d dones=%0d done2_at=%0d want 0/0 16 2 97",
               bba, bbb, n_strobe - sb, n_done - db, d_stamp[db+1] - e0a);
    end
    for (int n = 0; n < 16; n++) begin
      eh = (n < 8) ? model_h(n, xa) : model_h(n - 8, xb);
      total++;
      if (s_idx[sb+n] !== 3'(n % 8) || s_data[sb+n] !== eh ||
          s_stamp[sb+n] !== e0a + 6*(n % 8) + 6 + ((n < 8) ? 0 : 49)) begin
        bad++;
        $display("FAIL b2b_strobe%0d got idx=%0d data=%0d at=%0d want idx=%0d data=%0d at=%0d",
                 n, s_idx[sb+n], s_data[sb+n], s_stamp[sb+n] - e0a, n % 8, eh,
                 6*(n % 8) + 6 + ((n < 8) ? 0 : 49));
      end
    end
  endtask

  task automatic test_mid_reset();
    xvec_t xv;
    int e0, bb, sb, db;
    logic [15:0] eh;
    rand_roms();
    xv = xvec_t'({$urandom, $urandom});
    sb = n_strobe;
    db = n_done;
    @(negedge clk);
    start = 1'b1;
    set_x(xv);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, h_valid, done, h_idx, h_data, rom_addr} !== '0 || h_vec !== '0) begin
      bad++;
      $display("FAIL midreset_outputs busy=%b hv=%b done=%b idx=%0d data=%0d addr=%0d vec=%h want 0",
               busy, h_valid, done, h_idx, h_data, rom_addr, h_vec);
    end
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    total++;
    if (n_done !== db || n_strobe - sb !== 3) begin
      bad++;
      $display("FAIL midreset_abort dones=%0d strobes=%0d want 0 3", n_done - db, n_strobe - sb);
    end
    xv = xvec_t'({$urandom, $urandom});
    sb = n_strobe;
    db = n_done;
    drive_run(xv, -1, -1, 1'b0, 1'b0, e0, bb);
    repeat (3) @(negedge clk);
    total++;
    if (bb !== 0 || n_strobe - sb !== 8 || n_done - db !== 1 || d_stamp[db] !== e0 + 48) begin
      bad++;
      $display("FAIL midreset_rerun busy_bad=%0d strobes=%0d dones=%0d want 0 8 1",
               bb, n_strobe - sb, n_done - db);
    end
    for (int n = 0; n < 8; n++) begin
      eh = model_h(n, xv);
      total++;
      if (s_idx[sb+n] !== 3'(n) || s_data[sb+n] !== eh || s_stamp[sb+n] !== e0 + 6*n + 6) begin
        bad++;
        $display("FAIL rerun_strobe%0d got idx=%0d data=%0d at=%0d want idx=%0d data=%0d at=%0d",
                 n, s_idx[sb+n], s_data[sb+n], s_stamp[sb+n] - e0, n, eh, 6*n + 6);
      end
    end
  endtask

  initial begin
    start = 1'b0;
    rst_n = 1'b0;
    set_x('0);
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) wrom[n][i] = 16'd0;
      brom[n] = 16'd0;
    end
    test_reset();
    test_patterns();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
